debug_port: RTL and testbench
=============================

DEBUG_PORT -- requirements
Module: debug_port

Interface
REQ-001 Parameter DEPTH, default 4: record FIFO depth in records; power of two, at least 2.
REQ-002 Parameter HDR, default 8'hA5: frame header byte.
REQ-003 clk  in  1: single clock; all state updates on its rising edge.
REQ-004 rst  in  1: reset, asynchronous and active-low; no other clock or reset exists.
REQ-005 commit_valid  in  1: the core committed one instruction this cycle.
REQ-006 commit_pc  in  32: PC of the committed instruction.
REQ-007 commit_inst  in  32: encoding of the committed instruction.
REQ-008 halt  in  1: core halt flag, sampled with each commit.
REQ-009 err  in  1: core error flag, sampled with each commit.
REQ-010 enable  in  1: capture enable; when 0, commits are neither stored nor counted as drops.
REQ-011 tx_valid  out  1: tx_data holds a valid byte.
REQ-012 tx_data  out  8: outgoing trace byte.
REQ-013 tx_ready  in  1: host accepts the byte; a transfer occurs when tx_valid and tx_ready are both 1.
REQ-014 overflow  out  1: sticky flag; set when a commit is dropped.
REQ-015 drop_cnt  out  8: number of dropped commits, saturating.
REQ-016 level  out  $clog2(DEPTH)+1: FIFO occupancy in records.
REQ-017 drained  out  1: a halt record has been fully sent and the FIFO is empty.

Function
REQ-018 Frame format: 10 bytes, in this order:
  - HDR
  - commit_pc[31:24], [23:16], [15:8], [7:0]
  - commit_inst[31:24] .. [7:0]
  - status byte {6'b0, err, halt}
REQ-019 Push: on each edge with commit_valid=1 and enable=1, the record {pc, inst, err, halt} is written to the FIFO if level<DEPTH, or if level=DEPTH and a pop occurs on the same edge.
REQ-020 Drop: otherwise the commit is dropped; overflow is set to 1 and drop_cnt increments, saturating at 8'hFF.
REQ-021 Transmit FSM states: IDLE, HDR, BODY (byte index 0..7), STAT.
REQ-022 IDLE to HDR on the edge where level is nonzero.
REQ-023 HDR to BODY on a transfer.
REQ-024 BODY: the index advances on each transfer; leaves to STAT after index 7 is transferred.
REQ-025 STAT: on a transfer the FIFO head is popped; next state is HDR if another record remains after the pop, otherwise IDLE.
REQ-026 tx_valid is 1 in states HDR, BODY and STAT, and 0 in IDLE.
REQ-027 While tx_valid=1 and tx_ready=0, tx_data and the FSM state hold.
REQ-028 tx_data is driven from the FIFO head and the state/index; the head is not popped before its STAT byte transfers.
REQ-029 Latency: a commit captured at edge N into an empty FIFO while IDLE produces tx_valid=1 with tx_data=HDR in cycle N+1.
REQ-030 Back-to-back frames: with tx_ready held at 1, consecutive frames have no idle cycle between them.
REQ-031 level updates on the same edge as a push and/or pop; a simultaneous push and pop leaves level unchanged.
REQ-032 drained is set on the pop of a record with halt=1 that leaves the FIFO empty.
REQ-033 drained clears on the next accepted push.
REQ-034 Wrap-around: FIFO read and write pointers wrap modulo DEPTH.

Reset
REQ-035 With rst=0, immediately and asynchronously:
  - state = IDLE; tx_valid = 0; tx_data = 8'h00
  - FIFO pointers reset; level = 0
  - overflow = 0; drop_cnt = 0; drained = 0
REQ-036 Reset asserted mid-frame abandons the frame; no partial bytes are sent after reset deasserts.
REQ-037 Reset deassertion takes effect at a rising edge; the first possible push is on that edge.

Structure
REQ-038 Shared package debug_pkg holds:
  - the tx state enum
  - FRAME_BYTES = 10
  - the default HDR value
  - a packed record struct {pc, inst, err, halt}
REQ-039 The FIFO storage and pointer logic is sub-module debug_fifo, parameterised by DEPTH and record width; the FSM and counters live in debug_port.

Verification
REQ-040 Single commit (pc=32'h1000, inst=32'h2008_0005, halt=0, err=0) with tx_ready=1 -> 10 consecutive bytes A5 00 00 10 00 20 08 00 05 00, starting one cycle after the commit; level returns to 0.
REQ-041 Same commit, tx_ready toggled 1,0,1,0... -> identical byte sequence; each byte held stable while tx_ready=0.
REQ-042 Six commits on consecutive cycles with tx_ready=0, DEPTH=4 -> level=4, overflow=1, drop_cnt=2; after tx_ready=1, exactly 4 frames are sent, in commit order.
REQ-043 Commit with halt=1 as the only record, tx_ready=1 -> status byte 8'h01; drained=1 after the STAT transfer; a new commit clears drained.
REQ-044 rst pulsed low during byte 5 of a frame -> tx_valid=0 immediately, level=0; after release, no residual bytes appear.
REQ-045 Push coinciding with the STAT pop while level=DEPTH -> no drop and level stays at DEPTH; pointers wrap correctly over 3 full FIFO passes.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and helpers for the commit-trace debug port.
package debug_pkg;

    localparam int unsigned FRAME_BYTES = 10;
    localparam logic [7:0]  DEFAULT_HDR = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY,
        ST_STAT
    } tx_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
        logic        halt;
    } trace_rec_t;

    localparam int unsigned REC_W = $bits(trace_rec_t);

    // Byte presented on the wire for a given state/body index of a record.
    function automatic logic [7:0] frame_byte(input tx_state_e  st,
                                              input logic [2:0] idx,
                                              input trace_rec_t rec,
                                              input logic [7:0] hdr);
        logic [63:0] body;
        logic [7:0]  b;
        body = {rec.pc, rec.inst};
        b    = 8'h00;
        case (st)
            ST_HDR:  b = hdr;
            ST_BODY: b = body[{3'd7 - idx, 3'b000} +: 8];
            ST_STAT: b = {6'b0, rec.err, rec.halt};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/debug_fifo.sv
// Record FIFO with a look-ahead view of the head as it will be after this edge.
module debug_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         head_next_c,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [$clog2(DEPTH):0]   level_next_c
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    after_pop;

    // A push into a slot that becomes the head is forwarded straight from wdata.
    always_comb begin
        level_next_c = level_q + LW'(push_i) - LW'(pop_i);
        after_pop    = level_q - LW'(pop_i);
        rd_ptr_d     = rd_ptr_q + PW'(pop_i);
        head_next_c  = (after_pop == '0) ? wdata_i : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push_i);
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_next_c;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/debug_port.sv
// Commit-trace port: buffers committed instructions and streams them as 10-byte frames.
module debug_port
    import debug_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter logic [7:0]  HDR   = DEFAULT_HDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   commit_valid,
    input  logic [31:0]            commit_pc,
    input  logic [31:0]            commit_inst,
    input  logic                   halt,
    input  logic                   err,
    input  logic                   enable,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic                   overflow,
    output logic [7:0]             drop_cnt,
    output logic [$clog2(DEPTH):0] level,
    output logic                   drained
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    tx_state_e   state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        halt_q;
    logic        overflow_q;
    logic [7:0]  drop_cnt_q;
    logic        drained_q;

    logic        xfer, pop, cap, full, push, drop;
    logic [LW-1:0] level_now, level_next;
    trace_rec_t  wrec, head_next;

    assign wrec = '{pc: commit_pc, inst: commit_inst, err: err, halt: halt};
    assign xfer = tx_valid_q & tx_ready;
    assign pop  = xfer & (state_q == ST_STAT);
    assign cap  = commit_valid & enable;
    assign full = (level_now == LW'(DEPTH));
    assign push = cap & (~full | pop);
    assign drop = cap & ~push;

    debug_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .pop_i        (pop),
        .wdata_i      (wrec),
        .head_next_c  (head_next),
        .level_o      (level_now),
        .level_next_c (level_next)
    );

    // Next state plus the byte that will sit on the wire after this edge.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (level_next != '0) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (xfer) begin
                    state_d = ST_BODY;
                    idx_d   = 3'd0;
                end
            end
            ST_BODY: begin
                if (xfer) begin
                    if (idx_q == 3'(FRAME_BYTES - 3)) state_d = ST_STAT;
                    else                              idx_d   = idx_q + 3'd1;
                end
            end
            ST_STAT: begin
                if (xfer) state_d = (level_next != '0) ? ST_HDR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        tx_valid_d = (state_d != ST_IDLE);
        tx_data_d  = frame_byte(state_d, idx_d, head_next, HDR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            halt_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'h00;
            drained_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            halt_q     <= head_next.halt;
            overflow_q <= overflow_q | drop;
            if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
            if (push)                                          drained_q <= 1'b0;
            else if (pop && halt_q && (level_next == '0))      drained_q <= 1'b1;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign level    = level_now;
    assign drained  = drained_q;

endmodule

// File: tb/tb_debug_port.sv
// Directed and random stimulus for debug_port against a queue-based frame model.
module tb_debug_port;
    import debug_pkg::*;

    localparam int         DEPTH  = 4;
    localparam logic [7:0] HDR_TB = 8'hA5;
    localparam logic [7:0] EXP40 [10] = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h00,
                                          8'h20, 8'h08, 8'h00, 8'h05, 8'h00};

    logic        clk;
    logic        rst;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
    logic        halt;
    logic        err;
    logic        enable;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic [2:0]  level;
    logic        drained;

    int n_checks = 0;
    int n_err    = 0;

    trace_rec_t mq[$];
    int         m_sent = 0;
    bit         m_ovf  = 0;
    int         m_drop = 0;
    bit         m_drn  = 0;
    bit         cap_on = 0;
    logic [7:0] got[$];

    debug_port #(.DEPTH(DEPTH), .HDR(HDR_TB)) dut (
        .clk          (clk),
        .rst          (rst),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .halt         (halt),
        .err          (err),
        .enable       (enable),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .level        (level),
        .drained      (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // k-th byte of the frame carrying record r.
    function automatic logic [7:0] exp_byte(input trace_rec_t r, input int k);
        logic [63:0] b;
        b = {r.pc, r.inst};
        if (k == 0) return HDR_TB;
        if (k == 9) return {6'b0, r.err, r.halt};
        return 8'(b >> (8 * (8 - k)));
    endfunction

    task automatic step(input logic cv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic h, input logic e, input logic en, input logic rdy);
        bit         xfer, pop, acc;
        trace_rec_t r, nr;
        @(negedge clk);
        commit_valid = cv; commit_pc = pc; commit_inst = inst;
        halt = h; err = e; enable = en; tx_ready = rdy;
        #1;
        chk("tx_valid", 32'(tx_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("tx_data", 32'(tx_data), 32'(exp_byte(mq[0], m_sent)));
        chk("level", 32'(level), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("drained", 32'(drained), 32'(m_drn));
        xfer = (mq.size() != 0) && rdy;
        pop  = xfer && (m_sent == 9);
        acc  = cv && en && ((mq.size() < DEPTH) || pop);
        if (cap_on && xfer) got.push_back(tx_data);
        if (xfer) m_sent++;
        if (pop) begin
            r = mq.pop_front();
            m_sent = 0;
            if (r.halt && mq.size() == 0) m_drn = 1;
        end
        if (acc) begin
            nr = '{pc: pc, inst: inst, err: e, halt: h};
            mq.push_back(nr);
            m_drn = 0;
        end else if (cv && en) begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        commit_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("rst_drained", 32'(drained), 32'h0);
        mq.delete(); m_sent = 0; m_ovf = 0; m_drop = 0; m_drn = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; commit_valid = 1'b0; commit_pc = '0; commit_inst = '0;
        halt = 1'b0; err = 1'b0; enable = 1'b1; tx_ready = 1'b0;
        #1;
        chk("init_tx_valid", 32'(tx_valid), 32'h0);
        chk("init_tx_data", 32'(tx_data), 32'h0);
        chk("init_level", 32'(level), 32'h0);
        chk("init_drop_cnt", 32'(drop_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Single commit, ready held high.
        cap_on = 1; got.delete();
        step(1'b1, 32'h1000, 32'h2008_0005, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(12);
        chk("f40_len", 32'(got.size()), 32'd10);
        for (int i = 0; i < 10 && i < got.size(); i++) chk("f40_byte", 32'(got[i]), 32'(EXP40[i]));
        chk("f40_level", 32'(level), 32'h0);

        // Same commit with ready toggling.
        got.delete();
        step(1'b1, 32'h1000, 32'h2008_0005, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 30; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, (i % 2) == 0);
        chk("f41_len", 32'(got.size()), 32'd10);
        for (int i = 0; i < 10 && i < got.size(); i++) chk("f41_byte", 32'(got[i]), 32'(EXP40[i]));

        // Halt record drains the port.
        got.delete();
        step(1'b1, 32'h4000, 32'h0000_0073, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(12);
        chk("halt_status", (got.size() == 10) ? 32'(got[9]) : 32'hFFFF, 32'h01);
        chk("drained_set", 32'(drained), 32'h1);
        step(1'b1, 32'h4004, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("drained_clr", 32'(drained), 32'h0);
        idle(12);

        // Overflow with ready low, then drain in order.
        reset_pulse();
        got.delete();
        for (int i = 0; i < 6; i++)
            step(1'b1, 32'h100 + 32'(i * 4), 32'(i), 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_drops", 32'(drop_cnt), 32'd2);
        idle(50);
        chk("ovf_len", 32'(got.size()), 32'd40);
        for (int k = 0; k < 4 && got.size() == 40; k++)
            chk("ovf_order", 32'(got[10 * k + 4]), 32'(8'(k * 4)));

        // Reset in the middle of a frame.
        reset_pulse();
        step(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(5);
        reset_pulse();
        idle(20);

        // Continuous commits: push on the STAT pop while full, pointers wrap.
        reset_pulse();
        for (int i = 0; i < 130; i++)
            step(1'b1, 32'h8000 + 32'(i), ~32'(i), 1'b0, 1'(i % 3 == 0), 1'b1, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("wrap_level", 32'(level), 32'd4);
        idle(50);

        // Drop counter saturation.
        reset_pulse();
        for (int i = 0; i < 300; i++)
            step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sat_drops", 32'(drop_cnt), 32'hFF);
        idle(50);

        // Randomized traffic.
        reset_pulse();
        for (int i = 0; i < 800; i++)
            step(1'($urandom_range(0, 1)), $urandom, $urandom,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
        idle(60);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
